// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
package pc_fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP_DEF   = 32'd4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_ctrl_pc_incr.sv
// Sequential next-PC adder; wraps modulo 2^32 with no carry out.
module pc_incr
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] STEP = PC_STEP_DEF
) (
  input  logic [31:0] pc,
  output logic [31:0] pc_next
);

  assign pc_next = pc + STEP;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch controller: one outstanding imem request, payload held for IF/ID until accepted.
// Optional feature macro: PC_ALIGN_CHECK_EN (force-align redirect targets, flag misalignment).
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
  parameter logic [31:0] PC_STEP   = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc4_o
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  logic [31:0]  redirect_tgt;
  logic         redirect_mis;

  pc_incr #(.STEP(PC_STEP)) u_pc_incr (
    .pc      (pc),
    .pc_next (pc_next)
  );

  // Redirect target, optionally forced to word alignment.
  always_comb begin
`ifdef PC_ALIGN_CHECK_EN
    redirect_tgt = {redirect_pc_i[31:2], 2'b00};
    redirect_mis = |redirect_pc_i[1:0];
`else
    redirect_tgt = redirect_pc_i;
    redirect_mis = 1'b0;
`endif
  end

  // Request drops the instant reset hits, since the state register clears asynchronously.
  assign imem_req_o  = (state == ST_REQ) & ~stall_i & ~redirect_i;
  assign imem_addr_o = pc;

  // Fetch FSM: redirect beats stall, stall beats ack and consumer handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_VEC;
      if_valid_o <= 1'b0;
      if_instr_o <= 32'h0000_0000;
      if_pc_o    <= 32'h0000_0000;
      if_pc4_o   <= 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
`ifdef PC_ALIGN_CHECK_EN
      misalign_o <= redirect_i & redirect_mis;
`endif
      if (redirect_i) begin
        pc         <= redirect_tgt;
        if_valid_o <= 1'b0;
        state      <= ST_REQ;
      end else if (stall_i) begin
        state <= state;
      end else begin
        case (state)
          ST_IDLE: state <= ST_REQ;
          ST_REQ: begin
            if (imem_ack_i) begin
              if_instr_o <= imem_rdata_i;
              if_pc_o    <= pc;
              if_pc4_o   <= pc_next;
              if_valid_o <= 1'b1;
              pc         <= pc_next;
              state      <= ST_HOLD;
            end else begin
              state <= ST_REQ;
            end
          end
          ST_HOLD: begin
            if (if_ready_i) begin
              if_valid_o <= 1'b0;
              state      <= ST_REQ;
            end else begin
              state <= ST_HOLD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Unused in the default build; keeps the lint view consistent across configurations.
  logic unused_mis;
  assign unused_mis = redirect_mis;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, redirect_i, imem_ack_i, if_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, if_valid_o;
  logic [31:0] imem_addr_o, if_instr_o, if_pc_o, if_pc4_o;
  logic        mis_obs;

  int checks = 0;
  int errors = 0;

  // Reference model: fetch pointer, whether fetching has begun, and a single-slot payload buffer.
  logic [31:0] m_pc;
  bit          m_started;
  bit          m_full;
  logic [31:0] m_instr, m_ipc, m_ipc4;
  bit          m_mis;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .if_valid_o    (if_valid_o),
    .if_ready_i    (if_ready_i),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc4_o      (if_pc4_o)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_o    (mis_obs)
`endif
  );

`ifndef PC_ALIGN_CHECK_EN
  assign mis_obs = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_started = 0; m_full = 0;
    m_instr = 32'h0; m_ipc = 32'h0; m_ipc4 = 32'h0; m_mis = 0;
  endtask

  // One cycle: drive inputs, compare outputs with the model, clock, advance the model.
  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit ak, input logic [31:0] rdat, input bit rdy);
    bit exp_req;
    stall_i = st; redirect_i = rd; redirect_pc_i = rpc;
    imem_ack_i = ak; imem_rdata_i = rdat; if_ready_i = rdy;
    #1;
    exp_req = m_started && !m_full && !st && !rd;
    check("req", {31'd0, imem_req_o}, {31'd0, exp_req});
    check("addr", imem_addr_o, m_pc);
    check("valid", {31'd0, if_valid_o}, {31'd0, m_full});
    check("instr", if_instr_o, m_instr);
    check("if_pc", if_pc_o, m_ipc);
    check("if_pc4", if_pc4_o, m_ipc4);
    check("misalign", {31'd0, mis_obs}, {31'd0, m_mis});
    @(posedge clk);
    m_mis = 0;
    if (rd) begin
`ifdef PC_ALIGN_CHECK_EN
      m_mis = (rpc % 4) != 0;
      m_pc  = rpc - (rpc % 4);
`else
      m_pc  = rpc;
`endif
      m_full = 0; m_started = 1;
    end else if (st) begin
      // frozen
    end else if (!m_started) begin
      m_started = 1;
    end else if (!m_full) begin
      if (ak) begin
        m_instr = rdat; m_ipc = m_pc; m_ipc4 = m_pc + 32'd4;
        m_full = 1; m_pc = m_pc + 32'd4;
      end
    end else if (rdy) begin
      m_full = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    stall_i = 0; redirect_i = 0; redirect_pc_i = 32'h0;
    imem_ack_i = 0; imem_rdata_i = 32'h0; if_ready_i = 0;
    model_reset();
    #12;
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);
    check("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check("rst_pc4", if_pc4_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back fetches with immediate ack.
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'hA000_0000, 1);
    check("first_pc4", if_pc4_o, 32'h4);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'hA000_0004, 1);
    check("second_pc4", if_pc4_o, 32'h8);
    check("second_pc", if_pc_o, 32'h4);
    step(0, 0, 0, 0, 0, 1);

    // Ack delayed three cycles: address 0x8 held.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 32'hDEAD_BEEF, 1);
      check("held_addr", imem_addr_o, 32'h8);
    end
    step(0, 0, 0, 1, 32'hA000_0008, 0);
    // Consumer not ready for five cycles.
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 32'h1111_1111, 0);
    check("hold_instr", if_instr_o, 32'hA000_0008);
    step(0, 0, 0, 0, 0, 1);

    // Redirect coincident with ack: ack dropped, next fetch from 0x100.
    step(0, 1, 32'h100, 1, 32'h2222_2222, 1);
    check("redir_valid", {31'd0, if_valid_o}, 32'd0);
    check("redir_addr", imem_addr_o, 32'h100);
    step(0, 0, 0, 1, 32'hA000_0100, 1);
    step(0, 0, 0, 0, 0, 1);

    // Stall for three cycles in REQ, then redirect while still stalled.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 32'h3333_3333, 1);
    step(1, 1, 32'h100, 1, 32'h3333_3333, 1);
    step(0, 0, 0, 1, 32'hA100_0100, 1);
    step(0, 0, 0, 0, 0, 1);

    // Wrap at top of address space.
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    step(0, 0, 0, 1, 32'hCAFE_0000, 0);
    check("wrap_pc4", if_pc4_o, 32'h0);
    check("wrap_addr", imem_addr_o, 32'h0);
    step(0, 0, 0, 0, 0, 1);

`ifdef PC_ALIGN_CHECK_EN
    step(0, 1, 32'h102, 0, 0, 1);
    check("mis_pulse", {31'd0, mis_obs}, 32'd1);
    check("mis_addr", imem_addr_o, 32'h100);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 32'h200, 0, 0, 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
`ifndef PC_ALIGN_CHECK_EN
      tgt = tgt & 32'hFFFF_FFFC;
`endif
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, tgt,
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 9) < 6);
    end

    // Reset in the middle of an outstanding request.
    step(0, 1, 32'h40, 0, 0, 1);
    stall_i = 0; redirect_i = 0; imem_ack_i = 0;
    #1;
    check("pre_rst_req", {31'd0, imem_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_req", {31'd0, imem_req_o}, 32'd0);
    check("async_rst_addr", imem_addr_o, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 32'h5555_5555, 1);
    step(0, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
